// File: rtl/pilot_panel_pkg.sv
// Shared definitions for the pilot panel Avalon slave.
// Holds the register word addresses, the bit offset of the long-press flags,
// the LED mode encodings and the per-channel press FSM state encoding.
package pilot_panel_pkg;

    localparam logic [1:0] ADDR_STATUS   = 2'd0;
    localparam logic [1:0] ADDR_EVENTS   = 2'd1;
    localparam logic [1:0] ADDR_LED_MODE = 2'd2;
    localparam logic [1:0] ADDR_IRQ_EN   = 2'd3;

    // Long-press flags sit in the upper half-word of EVENTS and IRQ_EN.
    localparam int unsigned LONG_OFS = 16;

    typedef enum logic [1:0] {
        LedOff    = 2'b00,
        LedOn     = 2'b01,
        LedBlink  = 2'b10,
        LedFollow = 2'b11
    } led_mode_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StPressed = 2'b01,
        StHeld    = 2'b10
    } press_state_e;

endpackage

// File: rtl/pilot_btn_channel.sv
// One button channel: 2-FF synchroniser, debounce filter and short/long press FSM.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   bp_i        raw asynchronous button pin
//   stable_o    debounced level, 1 = pressed
//   short_ev_o  one-cycle pulse when a press ends before the long threshold
//   long_ev_o   one-cycle pulse when a press reaches the long threshold
module pilot_btn_channel
    import pilot_panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bp_i,
    output logic stable_o,
    output logic short_ev_o,
    output logic long_ev_o
);

    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoldW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [DbW-1:0]   DbMax       = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax     = HoldW'(LONG_PRESS_CYCLES - 1);
    localparam logic             PinReleased = BTN_ACTIVE_LOW;

    logic [1:0]       sync_q;
    logic             synced;
    logic             stable_q, stable_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    press_state_e     state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;

    // Normalise so that 1 always means pressed.
    assign synced   = sync_q[1] ^ PinReleased;
    assign stable_o = stable_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Synchroniser resets to the released pin level so a button held
            // through reset is debounced from scratch as a new press.
            sync_q   <= {2{PinReleased}};
            stable_q <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= StIdle;
            hold_q   <= '0;
        end else begin
            sync_q   <= {sync_q[0], bp_i};
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
        end
    end

    // Counter only runs while the synced level disagrees with the stable one.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (synced != stable_q) begin
            if (db_cnt_q == DbMax) begin
                stable_d = synced;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        short_ev_o = 1'b0;
        long_ev_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (stable_q) begin
                    state_d = StPressed;
                    hold_d  = '0;
                end
            end
            StPressed: begin
                if (!stable_q) begin
                    short_ev_o = 1'b1;
                    state_d    = StIdle;
                end else if (hold_q == HoldMax) begin
                    // Counting stops here, so the hold counter never wraps.
                    long_ev_o = 1'b1;
                    state_d   = StHeld;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StHeld: begin
                if (!stable_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/pilot_panel_avalon.sv
// Autopilot button/LED panel as an Avalon-MM slave.
// Ports:
//   clk_clk, reset_reset          clock and synchronous active-high reset
//   avs_address .. avs_read_n     Avalon-MM slave request (2-bit word address)
//   avs_readdata                  read data, valid one cycle after the read
//   avs_writeresponsevalid_n      low for one cycle after each accepted write
//   irq                           level interrupt, |(EVENTS & IRQ_EN), registered
//   bp_i                          raw buttons (conduit)
//   led_o                         LED drives, active-high (conduit)
// Registers: 0 STATUS (RO), 1 EVENTS (W1C), 2 LED_MODE (RW), 3 IRQ_EN (RW).
module pilot_panel_avalon
    import pilot_panel_pkg::*;
#(
    parameter int unsigned N_CH              = 3,
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter int unsigned BLINK_HALF_PERIOD = 12500000,
    parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic            clk_clk,
    input  logic            reset_reset,
    input  logic [1:0]      avs_address,
    input  logic            avs_chipselect,
    input  logic            avs_write_n,
    input  logic [31:0]     avs_writedata,
    input  logic            avs_read_n,
    output logic [31:0]     avs_readdata,
    output logic            avs_writeresponsevalid_n,
    output logic            irq,
    input  logic [N_CH-1:0] bp_i,
    output logic [N_CH-1:0] led_o
);

    localparam int unsigned BlinkW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_HALF_PERIOD - 1);

    logic [N_CH-1:0]   stable, short_ev, long_ev;
    logic [N_CH-1:0]   short_q, short_d, long_q, long_d;
    logic [N_CH-1:0]   irq_en_short_q, irq_en_long_q;
    logic [2*N_CH-1:0] led_mode_q;
    logic [N_CH-1:0]   led_q, led_d;
    logic [31:0]       rd_word, readdata_q;
    logic              wr_ack_n_q, irq_q;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic              wr_en, rd_en;
    logic              unused_wdata;

    assign wr_en        = avs_chipselect & ~avs_write_n;
    assign rd_en        = avs_chipselect & ~avs_read_n;
    assign unused_wdata = ^avs_writedata;

    assign avs_readdata             = readdata_q;
    assign avs_writeresponsevalid_n = wr_ack_n_q;
    assign irq                      = irq_q;
    assign led_o                    = led_q;

    for (genvar i = 0; i < N_CH; i++) begin : gen_ch
        pilot_btn_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .BTN_ACTIVE_LOW   (BTN_ACTIVE_LOW)
        ) u_ch (
            .clk_i     (clk_clk),
            .rst_i     (reset_reset),
            .bp_i      (bp_i[i]),
            .stable_o  (stable[i]),
            .short_ev_o(short_ev[i]),
            .long_ev_o (long_ev[i])
        );
    end

    // W1C first, then OR in new events so a same-cycle set wins over the clear.
    always_comb begin
        short_d = short_q;
        long_d  = long_q;
        if (wr_en && avs_address == ADDR_EVENTS) begin
            short_d = short_d & ~avs_writedata[N_CH-1:0];
            long_d  = long_d & ~avs_writedata[LONG_OFS +: N_CH];
        end
        short_d = short_d | short_ev;
        long_d  = long_d | long_ev;
    end

    always_comb begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BlinkMax) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            unique case (led_mode_e'(led_mode_q[2*i +: 2]))
                LedOff:    led_d[i] = 1'b0;
                LedOn:     led_d[i] = 1'b1;
                LedBlink:  led_d[i] = blink_phase_q;
                LedFollow: led_d[i] = stable[i];
                default:   led_d[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        unique case (avs_address)
            ADDR_STATUS: rd_word[N_CH-1:0] = stable;
            ADDR_EVENTS: begin
                rd_word[N_CH-1:0]         = short_q;
                rd_word[LONG_OFS +: N_CH] = long_q;
            end
            ADDR_LED_MODE: rd_word[2*N_CH-1:0] = led_mode_q;
            ADDR_IRQ_EN: begin
                rd_word[N_CH-1:0]         = irq_en_short_q;
                rd_word[LONG_OFS +: N_CH] = irq_en_long_q;
            end
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            short_q        <= '0;
            long_q         <= '0;
            irq_en_short_q <= '0;
            irq_en_long_q  <= '0;
            led_mode_q     <= '0;
            led_q          <= '0;
            readdata_q     <= '0;
            wr_ack_n_q     <= 1'b1;
            irq_q          <= 1'b0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
        end else begin
            short_q <= short_d;
            long_q  <= long_d;
            if (wr_en && avs_address == ADDR_LED_MODE) begin
                led_mode_q <= avs_writedata[2*N_CH-1:0];
            end
            if (wr_en && avs_address == ADDR_IRQ_EN) begin
                irq_en_short_q <= avs_writedata[N_CH-1:0];
                irq_en_long_q  <= avs_writedata[LONG_OFS +: N_CH];
            end
            // rd_word comes from current state, so a colliding write is not visible.
            if (rd_en) begin
                readdata_q <= rd_word;
            end
            wr_ack_n_q    <= ~wr_en;
            irq_q         <= (|(short_q & irq_en_short_q)) | (|(long_q & irq_en_long_q));
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            led_q         <= led_d;
        end
    end

endmodule
